// File: rtl/whack_pkg.sv
// whack_pkg: shared definitions for the whack-a-mole controller.
//   - FSM state encoding for mole_scheduler
//   - field widths of the random box/delay/colour triple
//   - max_int helper used to size the mole timer
package whack_pkg;

  localparam int BOX_W     = 3;
  localparam int DELAY_W   = 2;
  localparam int COLOUR_W  = 3;
  localparam int NUM_BOXES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SHOW = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mole_timer.sv
// mole_timer: loadable down-counter advanced by a tick strobe.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   iLoad/iValue  - load the counter (load wins over a tick)
//   iTick         - decrement strobe; the count holds at zero
//   oZeroNext     - high on the tick that takes the count from 1 to 0
module mole_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         iLoad,
  input  logic [W-1:0] iValue,
  input  logic         iTick,
  output logic         oZeroNext
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = iValue;
    end else if (iTick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Independent of iLoad so the scheduler can use it to decide a reload.
  assign oZeroNext = iTick && (cnt_q == W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: runs one mole life cycle per random triple.
//   state | meaning
//   IDLE  | game stopped, nothing shown
//   REQ   | oRandEnb high, waiting for a valid random triple
//   WAIT  | random pre-show delay counting down on iTick
//   SHOW  | mole visible until its button is hit or UP_TICKS expire
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   iRun, iTick                  - game enable, timebase strobe
//   iRandValid/iBox/iDelay/iColour - random generator triple
//   iHit                         - debounced button pulses, one per box
//   oRandEnb                     - request to the random generator
//   oMoleValid/oMoleBox/oMoleColour - current mole to display
//   oHitPulse/oMissPulse         - one-cycle scoring strobes
//   oScore/oMisses               - saturating hit and miss counts
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int DELAY_UNIT = 250,
  parameter int UP_TICKS   = 750,
  parameter int SCORE_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                iRun,
  input  logic                iTick,
  input  logic                iRandValid,
  input  logic [BOX_W-1:0]    iBox,
  input  logic [DELAY_W-1:0]  iDelay,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic [NUM_BOXES-1:0] iHit,
  output logic                oRandEnb,
  output logic                oMoleValid,
  output logic [BOX_W-1:0]    oMoleBox,
  output logic [COLOUR_W-1:0] oMoleColour,
  output logic                oHitPulse,
  output logic                oMissPulse,
  output logic [SCORE_W-1:0]  oScore,
  output logic [SCORE_W-1:0]  oMisses
);

  localparam int TIMER_W = $clog2(max_int(4 * DELAY_UNIT, UP_TICKS) + 1);

  state_e              state_q;
  logic                rand_enb_q, mole_valid_q, hit_pulse_q, miss_pulse_q;
  logic [BOX_W-1:0]    box_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [SCORE_W-1:0]  score_q, misses_q;

  logic               tick_en, zero_next, timer_load, hit;
  logic [TIMER_W-1:0] timer_value, delay_ticks;

  assign delay_ticks = TIMER_W'((int'(iDelay) + 1) * DELAY_UNIT);
  assign tick_en     = iTick && ((state_q == ST_WAIT) || (state_q == ST_SHOW));
  assign hit         = iHit[box_q];

  always_comb begin
    timer_load  = 1'b0;
    timer_value = delay_ticks;
    if (iRun) begin
      if ((state_q == ST_REQ) && iRandValid) begin
        timer_load = 1'b1;
      end else if ((state_q == ST_WAIT) && zero_next) begin
        timer_load  = 1'b1;
        timer_value = TIMER_W'(UP_TICKS);
      end
    end
  end

  mole_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .iLoad     (timer_load),
    .iValue    (timer_value),
    .iTick     (tick_en),
    .oZeroNext (zero_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rand_enb_q   <= 1'b0;
      mole_valid_q <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      box_q        <= '0;
      colour_q     <= '0;
      score_q      <= '0;
      misses_q     <= '0;
    end else begin
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      if (!iRun) begin
        state_q      <= ST_IDLE;
        rand_enb_q   <= 1'b0;
        mole_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_REQ;
            rand_enb_q <= 1'b1;
          end
          ST_REQ: begin
            if (iRandValid) begin
              box_q      <= iBox;
              colour_q   <= iColour;
              rand_enb_q <= 1'b0;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (zero_next) begin
              mole_valid_q <= 1'b1;
              state_q      <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            // A hit takes priority over a timeout landing in the same cycle.
            if (hit) begin
              hit_pulse_q  <= 1'b1;
              mole_valid_q <= 1'b0;
              rand_enb_q   <= 1'b1;
              state_q      <= ST_REQ;
              if (score_q != '1) score_q <= score_q + SCORE_W'(1);
            end else if (zero_next) begin
              miss_pulse_q <= 1'b1;
              mole_valid_q <= 1'b0;
              rand_enb_q   <= 1'b1;
              state_q      <= ST_REQ;
              if (misses_q != '1) misses_q <= misses_q + SCORE_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oRandEnb    = rand_enb_q;
  assign oMoleValid  = mole_valid_q;
  assign oMoleBox    = box_q;
  assign oMoleColour = colour_q;
  assign oHitPulse   = hit_pulse_q;
  assign oMissPulse  = miss_pulse_q;
  assign oScore      = score_q;
  assign oMisses     = misses_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with DELAY_UNIT=2, UP_TICKS=3, SCORE_W=4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_mole_scheduler;

  logic       clk, reset_n, iRun, iTick, iRandValid;
  logic [2:0] iBox, iColour;
  logic [1:0] iDelay;
  logic [7:0] iHit;
  logic       oRandEnb, oMoleValid, oHitPulse, oMissPulse;
  logic [2:0] oMoleBox, oMoleColour;
  logic [3:0] oScore, oMisses;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score, exp_miss;

  mole_scheduler #(.DELAY_UNIT(2), .UP_TICKS(3), .SCORE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .iRun(iRun), .iTick(iTick),
    .iRandValid(iRandValid), .iBox(iBox), .iDelay(iDelay), .iColour(iColour),
    .iHit(iHit), .oRandEnb(oRandEnb), .oMoleValid(oMoleValid),
    .oMoleBox(oMoleBox), .oMoleColour(oMoleColour), .oHitPulse(oHitPulse),
    .oMissPulse(oMissPulse), .oScore(oScore), .oMisses(oMisses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic tick, input logic [7:0] hit);
    iTick = tick;
    iHit  = hit;
    @(posedge clk);
    #1;
    iTick = 1'b0;
    iHit  = 8'h00;
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_score"}, int'(oScore), exp_score);
    chk({tag, "_miss"}, int'(oMisses), exp_miss);
  endtask

  // Wait for a request, hand over one triple, then tick through the delay
  // with an idle cycle between ticks; the mole must appear only after the
  // (dly+1)*2-th tick.
  task automatic serve(input int box, input int dly, input int col);
    int budget = 0;
    while (oRandEnb !== 1'b1 && budget < 10) begin
      cyc(1'b0, 8'h00);
      budget++;
    end
    chk("req_enb", int'(oRandEnb), 1);
    iRandValid = 1'b1;
    iBox       = 3'(box);
    iDelay     = 2'(dly);
    iColour    = 3'(col);
    cyc(1'b0, 8'h00);
    iRandValid = 1'b0;
    iBox       = 3'd0;
    iDelay     = 2'd0;
    iColour    = 3'd0;
    chk("enb_drop", int'(oRandEnb), 0);
    for (int t = 0; t < (dly + 1) * 2; t++) begin
      chk("wait_hidden", int'(oMoleValid), 0);
      cyc(1'b0, 8'h00);
      cyc(1'b1, 8'h00);
    end
    chk("show_valid", int'(oMoleValid), 1);
    chk("show_box", int'(oMoleBox), box);
    chk("show_colour", int'(oMoleColour), col);
  endtask

  initial begin
    logic [7:0] hbit;
    reset_n = 1'b0; iRun = 1'b0; iTick = 1'b0; iRandValid = 1'b0;
    iBox = 3'd0; iDelay = 2'd0; iColour = 3'd0; iHit = 8'h00;
    exp_score = 0;
    exp_miss  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(oMoleValid), 0);
    chk("rst_enb", int'(oRandEnb), 0);
    chk("rst_box", int'(oMoleBox), 0);
    chk("rst_pulses", int'({oHitPulse, oMissPulse}), 0);
    chk_scores("rst");

    // Released with iRun low: stays idle.
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'hFF);
      chk("idle_enb", int'(oRandEnb), 0);
    end
    chk("idle_valid", int'(oMoleValid), 0);
    chk_scores("idle");

    // First mole and a hit on its box.
    iRun = 1'b1;
    cyc(1'b0, 8'h00);
    chk("req_rise", int'(oRandEnb), 1);
    serve(5, 1, 3);
    cyc(1'b0, 8'b0010_0000);
    exp_score = 1;
    chk("hit_pulse", int'(oHitPulse), 1);
    chk("hit_nomiss", int'(oMissPulse), 0);
    chk("hit_clear", int'(oMoleValid), 0);
    chk("hit_reenb", int'(oRandEnb), 1);
    chk_scores("hit1");
    cyc(1'b0, 8'h00);
    chk("hit_onecyc", int'(oHitPulse), 0);

    // Timeout with a press on the wrong box.
    serve(5, 0, 6);
    cyc(1'b0, 8'b0000_0100);
    chk("wrong_box", int'(oHitPulse), 0);
    chk("wrong_valid", int'(oMoleValid), 1);
    cyc(1'b1, 8'b0000_0100);
    cyc(1'b1, 8'h00);
    chk("pre_timeout", int'(oMoleValid), 1);
    cyc(1'b1, 8'b1101_1111);
    exp_miss = 1;
    chk("miss_pulse", int'(oMissPulse), 1);
    chk("miss_nohit", int'(oHitPulse), 0);
    chk("miss_clear", int'(oMoleValid), 0);
    chk_scores("miss1");
    cyc(1'b0, 8'h00);
    chk("miss_onecyc", int'(oMissPulse), 0);

    // Hit (multiple bits set) together with the final tick: hit wins.
    serve(5, 3, 1);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'hFF);
    exp_score = 2;
    chk("tie_hit", int'(oHitPulse), 1);
    chk("tie_nomiss", int'(oMissPulse), 0);
    chk_scores("tie");

    // Saturation: 14 more hits, 16 in total.
    for (int i = 0; i < 14; i++) begin
      serve(i % 8, 0, (i + 1) % 8);
      hbit = 8'd1 << (i % 8);
      cyc(1'b0, hbit);
      if (exp_score < 15) exp_score++;
      chk("sat_pulse", int'(oHitPulse), 1);
      chk_scores("sat");
    end

    // iRun low mid-SHOW: mole cleared, no pulse, scores hold.
    serve(2, 0, 4);
    iRun = 1'b0;
    cyc(1'b1, 8'b0000_0100);
    chk("stop_valid", int'(oMoleValid), 0);
    chk("stop_enb", int'(oRandEnb), 0);
    chk("stop_pulses", int'({oHitPulse, oMissPulse}), 0);
    chk_scores("stop");
    cyc(1'b1, 8'b0000_0100);
    chk("stop_nopulse", int'({oHitPulse, oMissPulse}), 0);
    chk_scores("stop2");

    // Async reset mid-SHOW: cleared without waiting for a clock edge.
    iRun = 1'b1;
    serve(6, 0, 7);
    #2;
    reset_n = 1'b0;
    #1;
    exp_score = 0;
    exp_miss  = 0;
    chk("arst_valid", int'(oMoleValid), 0);
    chk("arst_box", int'(oMoleBox), 0);
    chk("arst_pulses", int'({oHitPulse, oMissPulse}), 0);
    chk_scores("arst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 8'h00);
    chk("arst_restart", int'(oRandEnb), 1);

    // Reset mid-WAIT, then a full clean mole afterwards.
    iRandValid = 1'b1; iBox = 3'd1; iDelay = 2'd2; iColour = 3'd2;
    cyc(1'b0, 8'h00);
    iRandValid = 1'b0;
    cyc(1'b1, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("wrst_valid", int'(oMoleValid), 0);
    chk("wrst_enb", int'(oRandEnb), 0);
    chk_scores("wrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b1, 8'h00);
    chk("wrst_hidden", int'(oMoleValid), 0);
    serve(3, 1, 5);
    cyc(1'b0, 8'b0000_1000);
    exp_score = 1;
    chk("final_hit", int'(oHitPulse), 1);
    chk_scores("final");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
